alu_exec_unit: RTL and testbench

Parametrised ALU execution unit that takes the 2-bit ALUOp and 6-bit funct field from the main decoder and performs the selected operation on two operands. Single-cycle ops return a registered result one cycle after Start. Multiply and divide run on an iterative sequencer into internal HI/LO registers, with a Busy/Done handshake that stalls the datapath. It sits in the execute stage between the register file read ports and the writeback mux.

---
 rtl/alu_exec_unit.sv | 198 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle add/sub/logic/slt/mfhi/mflo plus iterative mult/div into HI/LO.
// Latency: 1 cycle for single-cycle ops; WIDTH+2 cycles for mult/div (shift-add / restoring, 1 bit per cycle).
// Backpressure: Busy=1 while mult/div iterates; Start is ignored then, so the datapath must stall on Busy.
//
// Ports: clk, reset (async, active-high); Start/ALUOp/ALUFn/A/B request inputs;
//        Result/Zero/Overflow/Illegal registered results, Done one-cycle completion pulse, Busy stall.
// Build option: define ALU_DIV_EN to build the divider; otherwise div/divu decode as illegal.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       ALUFn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             Illegal,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH, S_DONE} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     hi, lo;
    logic [WIDTH-1:0]     m;        // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   p;        // {acc, multiplier} or {remainder, quotient}
    logic                 neg_main; // negate product / quotient at finish
`ifdef ALU_DIV_EN
    logic                 op_div;
    logic                 neg_r;    // remainder takes dividend sign
    logic                 dzero;
`endif

    // ---------------- single-cycle decode ----------------
    logic [WIDTH-1:0] sum, diff, sc_res, mag_a, mag_b;
    logic             add_ovf, sub_ovf, sc_ovf, sc_ill, is_mul, is_div, op_signed;

    assign sum     = A + B;
    assign diff    = A - B;
    assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);

    always_comb begin
        sc_res    = '0;
        sc_ovf    = 1'b0;
        sc_ill    = 1'b0;
        is_mul    = 1'b0;
        is_div    = 1'b0;
        op_signed = 1'b0;
        case (ALUOp)
            2'b00: begin sc_res = sum;  sc_ovf = add_ovf; end
            2'b01: begin sc_res = diff; sc_ovf = sub_ovf; end
            2'b10: begin
                case (ALUFn)
                    6'b100000: begin sc_res = sum;  sc_ovf = add_ovf; end
                    6'b100001: sc_res = sum;
                    6'b100010: begin sc_res = diff; sc_ovf = sub_ovf; end
                    6'b100011: sc_res = diff;
                    6'b100100: sc_res = A & B;
                    6'b100101: sc_res = A | B;
                    6'b100110: sc_res = A ^ B;
                    6'b100111: sc_res = ~(A | B);
                    6'b101010: sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
                    6'b101011: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
                    6'b010000: sc_res = hi;
                    6'b010010: sc_res = lo;
                    6'b011000: begin is_mul = 1'b1; op_signed = 1'b1; end
                    6'b011001: is_mul = 1'b1;
`ifdef ALU_DIV_EN
                    6'b011010: begin is_div = 1'b1; op_signed = 1'b1; end
                    6'b011011: is_div = 1'b1;
`endif
                    default:   sc_ill = 1'b1;
                endcase
            end
            default: sc_ill = 1'b1;
        endcase
    end

    // Sequencer works on magnitudes; signs are reapplied at finish.
    assign mag_a = (op_signed && A[WIDTH-1]) ? -A : A;
    assign mag_b = (op_signed && B[WIDTH-1]) ? -B : B;

    // ---------------- iteration step ----------------
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   step_next, prod_fin;
`ifdef ALU_DIV_EN
    logic [WIDTH:0]       div_rs, div_diff;
    logic                 div_ge;
`endif

    always_comb begin
        // Shift-add: add multiplicand into the upper half when the current LSB is set, then shift right.
        mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        step_next = {mul_sum, p[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        // Restoring: shift next dividend bit into the remainder, subtract divisor if it fits.
        div_rs   = p[2*WIDTH-1:WIDTH-1];
        div_ge   = (div_rs >= {1'b0, m});
        div_diff = div_rs - {1'b0, m};
        if (op_div)
            step_next = {(div_ge ? div_diff[WIDTH-1:0] : div_rs[WIDTH-1:0]), p[WIDTH-2:0], div_ge};
`endif
        prod_fin = neg_main ? (~p + 1'b1) : p;
    end

    // ---------------- FSM and registered outputs ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            m        <= '0;
            p        <= '0;
            neg_main <= 1'b0;
`ifdef ALU_DIV_EN
            op_div   <= 1'b0;
            neg_r    <= 1'b0;
            dzero    <= 1'b0;
`endif
            Result   <= '0;
            Zero     <= 1'b0;
            Overflow <= 1'b0;
            Illegal  <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        if (is_mul || is_div) begin
                            state    <= S_RUN;
                            Busy     <= 1'b1;
                            Done     <= 1'b0;
                            cnt      <= CW'(WIDTH-1);
                            m        <= is_div ? mag_b : mag_a;
                            p        <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                            neg_main <= op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef ALU_DIV_EN
                            op_div   <= is_div;
                            neg_r    <= op_signed && A[WIDTH-1];
                            dzero    <= (B == '0);
`endif
                        end else begin
                            state    <= S_DONE;
                            Done     <= 1'b1;
                            Result   <= sc_res;
                            Zero     <= (sc_res == '0);
                            Overflow <= sc_ovf;
                            Illegal  <= sc_ill;
                        end
                    end else begin
                        state <= S_IDLE;
                        Done  <= 1'b0;
                    end
                end
                S_RUN: begin
                    p <= step_next;
                    if (cnt == '0)
                        state <= S_FINISH;
                    else
                        cnt <= cnt - 1'b1;
                end
                S_FINISH: begin
`ifdef ALU_DIV_EN
                    if (op_div) begin
                        // Divide by zero: quotient all ones; remainder already equals the dividend.
                        lo <= dzero ? '1 : (neg_main ? -p[WIDTH-1:0] : p[WIDTH-1:0]);
                        hi <= neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
                    end else begin
                        {hi, lo} <= prod_fin;
                    end
`else
                    {hi, lo} <= prod_fin;
`endif
                    state    <= S_DONE;
                    Busy     <= 1'b0;
                    Done     <= 1'b1;
                    Result   <= '0;
                    Zero     <= 1'b1;
                    Overflow <= 1'b0;
                    Illegal  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: scoreboard of predicted results, popped on Done.
// Latency: checks 1-cycle and WIDTH+2-cycle completion and Busy span.
// Backpressure: injects a Start while Busy and expects it to be dropped.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         Start;
    logic [1:0]   ALUOp;
    logic [5:0]   ALUFn;
    logic [W-1:0] A, B, Result;
    logic         Zero, Overflow, Illegal, Busy, Done;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .Start(Start), .ALUOp(ALUOp), .ALUFn(ALUFn),
        .A(A), .B(B), .Result(Result), .Zero(Zero), .Overflow(Overflow),
        .Illegal(Illegal), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         zero, ovf, ill, multi, wr;
        logic [W-1:0] nhi, nlo;
    } exp_t;

    exp_t         sb[$];
    exp_t         eb, gb;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    int           checks = 0, failures = 0;
    int           done_n;
    logic [5:0]   b2b_fn [6] = '{6'h20, 6'h23, 6'h24, 6'h26, 6'h2B, 6'h27};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model built on widened arithmetic and native division.
    function automatic exp_t predict(input logic [1:0] op, input logic [5:0] fn,
                                     input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [W:0]  s, d;
        logic [63:0] pr;
        e     = '0;
        e.nhi = m_hi;
        e.nlo = m_lo;
        s = {a[W-1], a} + {b[W-1], b};
        d = {a[W-1], a} - {b[W-1], b};
        case (op)
            2'b00: begin e.res = s[W-1:0]; e.ovf = s[W] ^ s[W-1]; end
            2'b01: begin e.res = d[W-1:0]; e.ovf = d[W] ^ d[W-1]; end
            2'b10: begin
                case (fn)
                    6'h20: begin e.res = s[W-1:0]; e.ovf = s[W] ^ s[W-1]; end
                    6'h21: e.res = a + b;
                    6'h22: begin e.res = d[W-1:0]; e.ovf = d[W] ^ d[W-1]; end
                    6'h23: e.res = a - b;
                    6'h24: e.res = a & b;
                    6'h25: e.res = a | b;
                    6'h26: e.res = a ^ b;
                    6'h27: e.res = ~(a | b);
                    6'h2A: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
                    6'h2B: e.res = (a < b) ? 1 : 0;
                    6'h10: e.res = m_hi;
                    6'h12: e.res = m_lo;
                    6'h18: begin
                        pr = longint'($signed(a)) * longint'($signed(b));
                        e.multi = 1'b1; e.wr = 1'b1; {e.nhi, e.nlo} = pr;
                    end
                    6'h19: begin
                        pr = {32'b0, a} * {32'b0, b};
                        e.multi = 1'b1; e.wr = 1'b1; {e.nhi, e.nlo} = pr;
                    end
                    6'h1A, 6'h1B: begin
`ifdef ALU_DIV_EN
                        e.multi = 1'b1; e.wr = 1'b1;
                        if (b == '0) begin
                            e.nlo = '1; e.nhi = a;
                        end else if (fn == 6'h1B) begin
                            e.nlo = a / b; e.nhi = a % b;
                        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                            e.nlo = a; e.nhi = '0;
                        end else begin
                            e.nlo = $signed(a) / $signed(b);
                            e.nhi = $signed(a) % $signed(b);
                        end
`else
                        e.ill = 1'b1;
`endif
                    end
                    default: e.ill = 1'b1;
                endcase
            end
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Issue one op, wait (bounded) for Done, then pop and compare. poke drives a Start mid-run.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [5:0] fn,
                          input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
        exp_t e, g;
        int   lat, busy_n;
        e = predict(op, fn, a, b);
        sb.push_back(e);
        if (e.wr) begin m_hi = e.nhi; m_lo = e.nlo; end
        Start = 1'b1; ALUOp = op; ALUFn = fn; A = a; B = b;
        @(posedge clk); #1;
        Start = 1'b0; A = $urandom; B = $urandom;
        lat = 1; busy_n = 0;
        while (!Done && lat < 200) begin
            busy_n += int'(Busy);
            Start = poke && (lat == 5);
            if (Start) begin ALUOp = 2'b00; A = 1; B = 1; end
            @(posedge clk); #1;
            lat++;
        end
        Start = 1'b0;
        g = sb.pop_front();
        if (!Done) begin
            check({tag, "/timeout"}, 64'(Done), 64'd1);
        end else begin
            check({tag, "/res"},  64'(Result),   64'(g.res));
            check({tag, "/zero"}, 64'(Zero),     64'(g.zero));
            check({tag, "/ovf"},  64'(Overflow), 64'(g.ovf));
            check({tag, "/ill"},  64'(Illegal),  64'(g.ill));
            check({tag, "/lat"},  64'(lat),      g.multi ? 64'(W + 2) : 64'd1);
            check({tag, "/busy"}, 64'(busy_n),   g.multi ? 64'(W + 1) : 64'd0);
        end
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; ALUOp = '0; ALUFn = '0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst/res",  64'(Result),   64'd0);
        check("rst/zero", 64'(Zero),     64'd0);
        check("rst/ovf",  64'(Overflow), 64'd0);
        check("rst/ill",  64'(Illegal),  64'd0);
        check("rst/busy", 64'(Busy),     64'd0);
        check("rst/done", 64'(Done),     64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("add_ovf",  2'b00, 6'h00, 32'h7FFF_FFFF, 32'h1, 1'b0);
        run_op("addu",     2'b10, 6'h21, 32'h7FFF_FFFF, 32'h1, 1'b0);
        run_op("add_f",    2'b10, 6'h20, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("sub_ovf",  2'b01, 6'h00, 32'h8000_0000, 32'h1, 1'b0);
        run_op("subu",     2'b10, 6'h23, 32'h8000_0000, 32'h1, 1'b0);
        run_op("slt",      2'b10, 6'h2A, 32'hFFFF_FFFF, 32'h1, 1'b0);
        run_op("sltu",     2'b10, 6'h2B, 32'hFFFF_FFFF, 32'h1, 1'b0);
        run_op("ill_fn",   2'b10, 6'h3F, 32'h1234, 32'h5678, 1'b0);
        run_op("ill_op",   2'b11, 6'h20, 32'h1234, 32'h5678, 1'b0);
        run_op("and",      2'b10, 6'h24, $urandom, $urandom, 1'b0);
        run_op("or",       2'b10, 6'h25, $urandom, $urandom, 1'b0);
        run_op("nor",      2'b10, 6'h27, 32'h0F0F_0000, 32'h0000_F0F0, 1'b0);

        run_op("mult",     2'b10, 6'h18, 32'hFFFF_FFFE, 32'h3, 1'b1);
        run_op("mfhi",     2'b10, 6'h10, 32'h0, 32'h0, 1'b0);
        run_op("mflo",     2'b10, 6'h12, 32'h0, 32'h0, 1'b0);
        run_op("multu",    2'b10, 6'h19, $urandom, $urandom, 1'b0);
        run_op("mfhi_u",   2'b10, 6'h10, 32'h0, 32'h0, 1'b0);
        run_op("mult_mn",  2'b10, 6'h18, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("mflo_mn",  2'b10, 6'h12, 32'h0, 32'h0, 1'b0);
        run_op("mfhi_mn",  2'b10, 6'h10, 32'h0, 32'h0, 1'b0);

        run_op("div",      2'b10, 6'h1A, 32'hFFFF_FFF9, 32'h2, 1'b0);
        run_op("div_lo",   2'b10, 6'h12, 32'h0, 32'h0, 1'b0);
        run_op("div_hi",   2'b10, 6'h10, 32'h0, 32'h0, 1'b0);
        run_op("divu0",    2'b10, 6'h1B, 32'h5, 32'h0, 1'b0);
        run_op("divu0_lo", 2'b10, 6'h12, 32'h0, 32'h0, 1'b0);
        run_op("divu0_hi", 2'b10, 6'h10, 32'h0, 32'h0, 1'b0);
        run_op("div_mn",   2'b10, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div_mn_lo",2'b10, 6'h12, 32'h0, 32'h0, 1'b0);
        run_op("div_s0",   2'b10, 6'h1A, 32'hFFFF_FFF0, 32'h0, 1'b0);
        run_op("div_s0_hi",2'b10, 6'h10, 32'h0, 32'h0, 1'b0);
        run_op("divu",     2'b10, 6'h1B, $urandom, 32'h3F1, 1'b0);
        run_op("divu_lo",  2'b10, 6'h12, 32'h0, 32'h0, 1'b0);

        // Back-to-back single-cycle ops: one Done and one result every cycle.
        for (int i = 0; i < 6; i++) begin
            A = $urandom; B = $urandom;
            eb = predict(2'b10, b2b_fn[i], A, B);
            sb.push_back(eb);
            Start = 1'b1; ALUOp = 2'b10; ALUFn = b2b_fn[i];
            @(posedge clk); #1;
            check("b2b/done", 64'(Done), 64'd1);
            gb = sb.pop_front();
            check("b2b/res", 64'(Result), 64'(gb.res));
        end
        Start = 1'b0;
        @(posedge clk); #1;

        // Reset during a multu: aborts, no Done, HI/LO cleared.
        Start = 1'b1; ALUOp = 2'b10; ALUFn = 6'h19; A = 32'h5; B = 32'h7;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("rstmid/busy_pre", 64'(Busy), 64'd1);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        done_n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            done_n += int'(Done);
        end
        check("rstmid/busy", 64'(Busy), 64'd0);
        check("rstmid/done", 64'(done_n), 64'd0);
        run_op("rstmid_lo", 2'b10, 6'h12, 32'h0, 32'h0, 1'b0);
        run_op("rstmid_hi", 2'b10, 6'h10, 32'h0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
